// File: rtl/obi_dmem_lrsc_adapter.sv
// OBI data port to single-outstanding L1 cache request adapter with LR/SC reservation tracking.
// Optional reservation expiry is enabled by defining RESV_TIMEOUT_EN.
module obi_dmem_lrsc_adapter #(
    parameter int unsigned RES_GRAN_LOG2 = 2,
    parameter int unsigned RESV_TIMEOUT  = 64
) (
    input  logic        clk_i,
    input  logic        nreset_i,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic [31:0] data_addr_i,
    input  logic [3:0]  data_be_i,
    input  logic        data_we_i,
    input  logic [31:0] data_wdata_i,
    input  logic        data_lr_sc_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        data_exokay_o,
    output logic        mem_valid_o,
    input  logic        mem_ready_i,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_resp_valid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,
    input  logic        snoop_inv_valid_i,
    input  logic [31:0] snoop_inv_addr_i
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;
    typedef enum logic [1:0] {OP_LOAD, OP_STORE, OP_LR, OP_SC} op_e;

    function automatic logic [31:0] gran(input logic [31:0] a);
        return a >> RES_GRAN_LOG2;
    endfunction

    state_e      state_q, state_d;
    op_e         op_q, op_d, op_in;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        mem_valid_q, mem_valid_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        exokay_q, exokay_d;
    logic        resv_valid_q, resv_valid_d;
    logic [31:0] resv_addr_q, resv_addr_d;

    logic        gnt;
    logic        addr_match;
    logic        snoop_hit;
    logic        snoop_new_hit;
    logic        sc_ok;
    logic        expired;

`ifdef RESV_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(RESV_TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign expired = resv_valid_q && (cnt_q == CNT_W'(RESV_TIMEOUT));
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(RESV_TIMEOUT);
    assign expired        = 1'b0;
`endif

    assign gnt           = data_req_i && (state_q == S_IDLE);
    assign data_gnt_o    = gnt;
    assign addr_match    = gran(data_addr_i) == gran(resv_addr_q);
    assign snoop_hit     = snoop_inv_valid_i && (gran(snoop_inv_addr_i) == gran(resv_addr_q));
    assign snoop_new_hit = snoop_inv_valid_i && (gran(snoop_inv_addr_i) == gran(addr_q));
    assign sc_ok         = resv_valid_q && !snoop_hit && !expired && addr_match;

    always_comb begin
        if (data_lr_sc_i) op_in = data_we_i ? OP_SC : OP_LR;
        else              op_in = data_we_i ? OP_STORE : OP_LOAD;
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        mem_valid_d  = 1'b0;
        rvalid_d     = 1'b0;
        rdata_d      = '0;
        err_d        = 1'b0;
        exokay_d     = 1'b0;
        // Snoop hits and expiry drop the reservation in any state; the cases below refine this.
        resv_valid_d = resv_valid_q && !snoop_hit && !expired;
        resv_addr_d  = resv_addr_q;
`ifdef RESV_TIMEOUT_EN
        cnt_d = cnt_q;
        if (resv_valid_q && !expired) cnt_d = cnt_q + CNT_W'(1);
`endif

        case (state_q)
            S_IDLE: begin
                if (gnt) begin
                    op_d    = op_in;
                    addr_d  = data_addr_i;
                    be_d    = data_be_i;
                    wdata_d = data_wdata_i;
                    if (op_in == OP_SC) begin
                        resv_valid_d = 1'b0;
                        if (sc_ok) begin
                            state_d     = S_REQ;
                            mem_valid_d = 1'b1;
                        end else begin
                            state_d  = S_RESP;
                            rvalid_d = 1'b1;
                        end
                    end else begin
                        state_d     = S_REQ;
                        mem_valid_d = 1'b1;
                        if (op_in == OP_STORE && addr_match) resv_valid_d = 1'b0;
                    end
                end
            end
            S_REQ: begin
                if (mem_ready_i) begin
                    state_d = S_WAIT;
                end else begin
                    mem_valid_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid_i) begin
                    state_d  = S_RESP;
                    rvalid_d = 1'b1;
                    rdata_d  = (op_q == OP_LOAD || op_q == OP_LR) ? mem_rdata_i : '0;
                    err_d    = mem_err_i;
                    // A SC only reaches the cache when it already passed at grant.
                    exokay_d = !mem_err_i && (op_q == OP_LR || op_q == OP_SC);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                if (op_q == OP_LR && !err_q) begin
                    resv_valid_d = !snoop_new_hit;
                    resv_addr_d  = addr_q;
`ifdef RESV_TIMEOUT_EN
                    cnt_d = '0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            state_q      <= S_IDLE;
            op_q         <= OP_LOAD;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            mem_valid_q  <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            exokay_q     <= 1'b0;
            resv_valid_q <= 1'b0;
            resv_addr_q  <= '0;
`ifdef RESV_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            mem_valid_q  <= mem_valid_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            exokay_q     <= exokay_d;
            resv_valid_q <= resv_valid_d;
            resv_addr_q  <= resv_addr_d;
`ifdef RESV_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign mem_valid_o   = mem_valid_q;
    assign mem_we_o      = (op_q == OP_STORE) || (op_q == OP_SC);
    assign mem_addr_o    = addr_q;
    assign mem_be_o      = be_q;
    assign mem_wdata_o   = wdata_q;
    assign data_rvalid_o = rvalid_q;
    assign data_rdata_o  = rdata_q;
    assign data_err_o    = err_q;
    assign data_exokay_o = exokay_q;

endmodule

// File: doc/obi_dmem_lrsc_adapter.md
Name: obi_dmem_lrsc_adapter

Overview:
- Sits between each core's OBI data port (req/gnt/rvalid with LR/SC flag) and that core's private L1 data-cache request port.
- Converts OBI into a single-outstanding valid/ready request plus a response strobe.
- Holds the hart's LR/SC reservation and generates data_exokay for the core.
- Snoop invalidations from the coherence fabric clear the reservation.

Parameters:
- RES_GRAN_LOG2, 2, log2 of reservation granule in bytes; address compare uses bits [31:RES_GRAN_LOG2].
- RESV_TIMEOUT, 64, cycles before a reservation expires; used only with RESV_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock
- nreset_i  in  1  synchronous active-low reset
- data_req_i  in  1  OBI request from core
- data_gnt_o  out  1  OBI grant
- data_addr_i  in  32  byte address
- data_be_i  in  4  byte enables
- data_we_i  in  1  write
- data_wdata_i  in  32  write data
- data_lr_sc_i  in  1  atomic: LR when we=0, SC when we=1
- data_rvalid_o  out  1  response valid, one cycle
- data_rdata_o  out  32  read data
- data_err_o  out  1  bus error
- data_exokay_o  out  1  exclusive okay
- mem_valid_o  out  1  cache request valid
- mem_ready_i  in  1  cache accepts request
- mem_we_o  out  1  cache write
- mem_addr_o  out  32  cache address
- mem_be_o  out  4  cache byte enables
- mem_wdata_o  out  32  cache write data
- mem_resp_valid_i  in  1  cache response strobe
- mem_rdata_i  in  32  cache read data
- mem_err_i  in  1  cache error, qualified by mem_resp_valid_i
- snoop_inv_valid_i  in  1  coherence invalidation
- snoop_inv_addr_i  in  32  invalidated address

Behaviour:
- One clock (clk_i). Reset is synchronous and active-low on nreset_i. All state updates on rising clk_i.
- Reset values:
  - state=IDLE.
  - All outputs 0.
  - Reservation valid=0, reservation address=0.
- FSM states: IDLE, REQ, WAIT, RESP.
- data_gnt_o = data_req_i & (state==IDLE), combinational.
- Grant cycle:
  - Latch addr, be, we, wdata, lr_sc.
  - Classify the request as LOAD, STORE, LR, SC.
- SC decision is made at grant:
  - SC passes iff reservation valid, addr[31:G] matches, and no same-cycle snoop hit on that granule.
  - Every SC (pass or fail) clears the reservation at grant.
- Transitions out of IDLE at grant:
  - Failed SC -> RESP. No cache request issued; data_rdata_o=0, exokay=0, err=0.
  - All other requests -> REQ.
- REQ:
  - mem_valid_o=1 with latched fields.
  - Fields are held stable until mem_ready_i.
  - On mem_valid_o & mem_ready_i -> WAIT.
- WAIT:
  - On mem_resp_valid_i, capture rdata/err -> RESP.
  - A response arriving in the same cycle as ready is ignored; the cache returns its response no earlier than the cycle after acceptance.
- RESP:
  - data_rvalid_o=1 for exactly one cycle, then -> IDLE.
  - Outputs: data_rdata_o=captured data (0 for stores/SC), data_err_o=captured err.
  - data_exokay_o=1 only for an LR without err, or a passed SC without err; else 0.
- Latency with a 0-wait cache (ready in REQ, response the next cycle): grant at cycle 0, rvalid at cycle 3. Failed SC: rvalid at cycle 1.
- No new grant while state!=IDLE. A new grant is allowed in the same cycle rvalid is asserted only after returning to IDLE, i.e. the next cycle.
- Reservation set: in RESP for an LR with err=0, reservation valid=1, address=latched addr.
- Reservation clear:
  - Snoop hit (snoop_inv_valid_i and snoop addr[31:G] == reservation addr[31:G]), any state.
  - Any SC at grant.
  - A non-atomic store by this hart to the reserved granule, at grant.
- Simultaneous snoop hit and LR set in RESP: the snoop wins; the reservation stays invalid, but exokay is still 1 for the LR.
- LR with err=1 leaves the reservation unchanged.
- Snoop during REQ/WAIT of a passed SC does not abort the write; the outcome is already decided.
- Reset mid-transaction: return to IDLE, drop the outstanding request, clear the reservation. No rvalid is issued for the dropped request.

Optional Feature:
- Macro: RESV_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(RESV_TIMEOUT+1) resets to 0 whenever the reservation is set.
  - It increments each cycle while the reservation is valid.
  - When the count reaches RESV_TIMEOUT, the reservation is cleared; the clear takes effect in that same cycle.
  - An SC granted in that cycle fails.
- Undefined: no counter; reservations persist until a clear event.

Test Plan:
- Plain load, addr 0x100, cache returns 0xDEADBEEF one cycle after ready -> rvalid 3 cycles after grant, rdata=0xDEADBEEF, exokay=0, err=0; mem_addr_o=0x100, mem_we_o=0.
- LR 0x200 then SC 0x200 wdata 0x5 -> LR exokay=1; SC issues cache write of 0x5 with be=0xF, exokay=1; a second SC 0x200 fails with rvalid 1 cycle after grant, exokay=0, no mem_valid_o.
- LR 0x300, snoop_inv 0x302 before SC -> SC fails, exokay=0, no cache write. Repeat with snoop 0x304 -> SC succeeds.
- Cache holds mem_ready_i=0 for 5 cycles -> mem_valid_o and all fields stable throughout, data_gnt_o=0 for a new data_req_i.
- LR 0x400 with mem_err_i=1 -> err=1, exokay=0; a following SC 0x400 fails. Also: nreset_i low in WAIT -> next cycle IDLE, no rvalid, reservation cleared.
- RESV_TIMEOUT_EN defined, RESV_TIMEOUT=8: LR 0x500, SC granted 10 cycles after the LR response -> exokay=0; an SC granted 4 cycles after the LR response -> exokay=1.
